// File: rtl/tcb_arb.sv
// rtl/tcb_arb.sv - merges BN TCB manager ports onto one subordinate port, with stall lock and response routing
// Round-robin priority with TCB_ARB_ROUND_ROBIN_EN defined; fixed priority (port 0 highest) otherwise.
module tcb_arb #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BN-1:0]        s_vld,
  input  logic [BN-1:0]        s_wen,
  input  logic [BN*DW/8-1:0]   s_ben,
  input  logic [BN*AW-1:0]     s_adr,
  input  logic [BN*DW-1:0]     s_wdt,
  output logic [BN*DW-1:0]     s_rdt,
  output logic [BN-1:0]        s_rdy,
  output logic                 m_vld,
  output logic                 m_wen,
  output logic [DW/8-1:0]      m_ben,
  output logic [AW-1:0]        m_adr,
  output logic [DW-1:0]        m_wdt,
  input  logic [DW-1:0]        m_rdt,
  input  logic                 m_rdy
);

  localparam int IW = $clog2(BN);
  localparam int BW = DW / 8;

  logic          lck_q, lck_d;
  logic [IW-1:0] lix_q, lix_d;
  logic          rvl_q, rvl_d;
  logic [IW-1:0] rix_q, rix_d;
  logic [IW-1:0] ptr;

  logic          arb_vld;
  logic [IW-1:0] arb_idx;
  logic          gnt_vld;
  logic [IW-1:0] gnt;
  logic          xfer;

`ifdef TCB_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Descending scan so the lowest offset from ptr is the one left standing.
  always_comb begin
    int j;
    arb_vld = 1'b0;
    arb_idx = '0;
    for (int k = BN - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % BN;
      if (s_vld[j]) begin
        arb_vld = 1'b1;
        arb_idx = IW'(j);
      end
    end
  end

  assign gnt     = lck_q ? lix_q : arb_idx;
  assign gnt_vld = lck_q | arb_vld;
  assign xfer    = m_vld & m_rdy;

  always_comb begin
    m_vld = 1'b0;
    m_wen = 1'bx;
    m_ben = 'x;
    m_adr = 'x;
    m_wdt = 'x;
    if (gnt_vld) begin
      m_vld = s_vld[gnt];
      m_wen = s_wen[gnt];
      m_ben = s_ben[int'(gnt)*BW +: BW];
      m_adr = s_adr[int'(gnt)*AW +: AW];
      m_wdt = s_wdt[int'(gnt)*DW +: DW];
    end
  end

  always_comb begin
    s_rdy = '0;
    s_rdt = '0;
    for (int i = 0; i < BN; i++) begin
      s_rdy[i] = gnt_vld && (int'(gnt) == i) && m_rdy;
      if (rvl_q && (int'(rix_q) == i)) begin
        s_rdt[i*DW +: DW] = m_rdt;
      end
    end
  end

  // Lock holds the grant across a stall; released by the completing handshake.
  always_comb begin
    lck_d = lck_q;
    lix_d = lix_q;
    rvl_d = xfer;
    rix_d = xfer ? gnt : rix_q;
    if (xfer) begin
      lck_d = 1'b0;
    end else if (m_vld) begin
      lck_d = 1'b1;
      lix_d = gnt;
    end
  end

`ifdef TCB_ARB_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (int'(gnt) == BN - 1) ? '0 : gnt + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lck_q <= 1'b0;
      lix_q <= '0;
      rvl_q <= 1'b0;
      rix_q <= '0;
    end else begin
      lck_q <= lck_d;
      lix_q <= lix_d;
      rvl_q <= rvl_d;
      rix_q <= rix_d;
    end
  end

endmodule

// File: tb/tb_tcb_arb.sv
// tb/tb_tcb_arb.sv - self-checking bench for tcb_arb (vector table, corner sequences, randomized model)
// Expectations follow TCB_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_tcb_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BN = 2;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [BN-1:0]     s_vld, s_wen, s_rdy;
  logic [BN*BW-1:0]  s_ben;
  logic [BN*AW-1:0]  s_adr;
  logic [BN*DW-1:0]  s_wdt, s_rdt;
  logic              m_vld, m_wen, m_rdy;
  logic [BW-1:0]     m_ben;
  logic [AW-1:0]     m_adr;
  logic [DW-1:0]     m_wdt, m_rdt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tcb_arb #(.AW(AW), .DW(DW), .BN(BN)) dut (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_wen(s_wen), .s_ben(s_ben), .s_adr(s_adr), .s_wdt(s_wdt),
    .s_rdt(s_rdt), .s_rdy(s_rdy),
    .m_vld(m_vld), .m_wen(m_wen), .m_ben(m_ben), .m_adr(m_adr), .m_wdt(m_wdt),
    .m_rdt(m_rdt), .m_rdy(m_rdy)
  );

  typedef struct {
    logic [1:0]  vld;
    logic        wen1;
    logic [3:0]  ben1;
    logic [31:0] adr1;
    logic [31:0] wdt1;
    logic        m_rdy;
    logic [31:0] m_rdt;
    logic        e_mvld;
    logic [31:0] e_madr;
    logic        e_mwen;
    logic [3:0]  e_mben;
    logic [31:0] e_mwdt;
    logic [1:0]  e_rdy;
    logic [31:0] e_rdt0;
    logic [31:0] e_rdt1;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic [1:0] vld, logic wen1, logic [3:0] ben1, logic [31:0] adr1,
                              logic [31:0] wdt1, logic mr, logic [31:0] mrdt, logic e_mvld,
                              logic [31:0] e_madr, logic e_mwen, logic [3:0] e_mben,
                              logic [31:0] e_mwdt, logic [1:0] e_rdy, logic [31:0] e_rdt0,
                              logic [31:0] e_rdt1);
    vec_t v;
    v.vld = vld; v.wen1 = wen1; v.ben1 = ben1; v.adr1 = adr1; v.wdt1 = wdt1;
    v.m_rdy = mr; v.m_rdt = mrdt; v.e_mvld = e_mvld; v.e_madr = e_madr; v.e_mwen = e_mwen;
    v.e_mben = e_mben; v.e_mwdt = e_mwdt; v.e_rdy = e_rdy; v.e_rdt0 = e_rdt0; v.e_rdt1 = e_rdt1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_vld = '0;
    m_rdy = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Randomized-phase reference state: whole-transaction view of each manager.
  bit          act[BN];
  logic [31:0] r_adr[BN];
  logic [31:0] r_wdt[BN];
  logic        r_wen[BN];
  logic [3:0]  r_ben[BN];
  int          lock_own, ptr_m, resp_own;

  initial begin
    s_wen = '0; s_ben = '1; s_adr = '0; s_wdt = '0; m_rdt = '0;
    do_reset();

    m_rdt = 32'hFFFF_FFFF;
    m_rdy = 1'b1;
    #1;
    chk("reset_mvld", m_vld, 0);
    chk("reset_srdy", s_rdy, 0);
    chk("reset_srdt", s_rdt, 0);
    tick();

    tbl[0]  = mk(2'b00, 0, 4'hF, 32'h100, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    tbl[1]  = mk(2'b10, 0, 4'hF, 32'h100, 0, 0, 0, 1, 32'h100, 0, 4'hF, 0, 2'b00, 0, 0);
    tbl[2]  = mk(2'b11, 0, 4'hF, 32'h100, 0, 0, 0, 1, 32'h100, 0, 4'hF, 0, 2'b00, 0, 0);
    tbl[3]  = mk(2'b11, 0, 4'hF, 32'h100, 0, 0, 0, 1, 32'h100, 0, 4'hF, 0, 2'b00, 0, 0);
    tbl[4]  = mk(2'b11, 0, 4'hF, 32'h100, 0, 1, 0, 1, 32'h100, 0, 4'hF, 0, 2'b10, 0, 0);
    tbl[5]  = mk(2'b01, 0, 4'hF, 32'h300, 0, 1, 32'hDEAD_0000, 1, 32'h200, 0, 4'hF, 0, 2'b01, 0, 32'hDEAD_0000);
    tbl[6]  = mk(2'b10, 0, 4'hF, 32'h300, 0, 1, 32'hA5A5_A5A5, 1, 32'h300, 0, 4'hF, 0, 2'b10, 32'hA5A5_A5A5, 0);
    tbl[7]  = mk(2'b00, 0, 4'hF, 32'h300, 0, 1, 32'h5A5A_5A5A, 0, 0, 0, 0, 0, 2'b00, 0, 32'h5A5A_5A5A);
    tbl[8]  = mk(2'b00, 0, 4'hF, 32'h300, 0, 1, 32'h0000_0033, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    tbl[9]  = mk(2'b10, 1, 4'h3, 32'h400, 32'h1234_5678, 0, 32'h44, 1, 32'h400, 1, 4'h3, 32'h1234_5678, 2'b00, 0, 0);
    tbl[10] = mk(2'b10, 1, 4'h3, 32'h400, 32'h1234_5678, 1, 32'h44, 1, 32'h400, 1, 4'h3, 32'h1234_5678, 2'b10, 0, 0);
    tbl[11] = mk(2'b00, 0, 4'hF, 32'h400, 0, 1, 32'h77, 0, 0, 0, 0, 0, 2'b00, 0, 32'h77);

    for (int r = 0; r < 12; r++) begin
      s_vld = tbl[r].vld;
      s_wen = {tbl[r].wen1, 1'b0};
      s_ben = {tbl[r].ben1, 4'hF};
      s_adr = {tbl[r].adr1, 32'h200};
      s_wdt = {tbl[r].wdt1, 32'h0};
      m_rdy = tbl[r].m_rdy;
      m_rdt = tbl[r].m_rdt;
      #1;
      chk($sformatf("vec%0d_mvld", r), m_vld, tbl[r].e_mvld);
      chk($sformatf("vec%0d_srdy", r), s_rdy, tbl[r].e_rdy);
      chk($sformatf("vec%0d_rdt0", r), s_rdt[31:0], tbl[r].e_rdt0);
      chk($sformatf("vec%0d_rdt1", r), s_rdt[63:32], tbl[r].e_rdt1);
      if (tbl[r].e_mvld) begin
        chk($sformatf("vec%0d_madr", r), m_adr, tbl[r].e_madr);
        chk($sformatf("vec%0d_mwen", r), m_wen, tbl[r].e_mwen);
        chk($sformatf("vec%0d_mben", r), m_ben, tbl[r].e_mben);
        chk($sformatf("vec%0d_mwdt", r), m_wdt, tbl[r].e_mwdt);
      end
      tick();
    end

    // Two continuous readers with m_rdy=1: alternation vs starvation.
    s_wen = '0;
    do_reset();
    s_vld = 2'b11;
    m_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
`ifdef TCB_ARB_ROUND_ROBIN_EN
      chk($sformatf("rr%0d_srdy", c), s_rdy, (c % 2 == 0) ? 2'b01 : 2'b10);
`else
      chk($sformatf("fixed%0d_srdy", c), s_rdy, 2'b01);
`endif
      tick();
    end

    // Reset during a stalled, locked s1 transfer: lock dropped, arbitration from port 0.
    do_reset();
    s_adr = {32'h500, 32'h200};
    s_vld = 2'b10;
    m_rdy = 1'b0;
    #1;
    chk("rstlk_madr", m_adr, 32'h500);
    tick();
    s_vld = 2'b11;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_rdy = 1'b1;
    m_rdt = 32'hFFFF_FFFF;
    #1;
    chk("rstlk_srdy", s_rdy, 2'b01);
    chk("rstlk_madr0", m_adr, 32'h200);
    // Reset on a completing transfer discards its response.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_vld = 2'b00;
    #1;
    chk("rstrsp_srdt", s_rdt, 0);
    tick();

    // Randomized traffic against a transaction-level reference.
    do_reset();
    for (int i = 0; i < BN; i++) act[i] = 1'b0;
    lock_own = -1; ptr_m = 0; resp_own = -1;
    for (int c = 0; c < 600; c++) begin
      int g;
      bit e_mvld, xf;
      bit do_rst;
      logic [BN-1:0] e_rdy;
      for (int i = 0; i < BN; i++) begin
        if (!act[i] && ($urandom_range(1, 0) == 1)) begin
          act[i]   = 1'b1;
          r_adr[i] = $urandom;
          r_wdt[i] = $urandom;
          r_wen[i] = 1'($urandom_range(1, 0));
          r_ben[i] = 4'($urandom_range(15, 0));
        end
        s_vld[i]            = act[i];
        s_wen[i]            = r_wen[i];
        s_ben[i*BW +: BW]   = r_ben[i];
        s_adr[i*AW +: AW]   = r_adr[i];
        s_wdt[i*DW +: DW]   = r_wdt[i];
      end
      m_rdy  = ($urandom_range(9, 0) < 7);
      m_rdt  = $urandom;
      do_rst = ($urandom_range(63, 0) == 0);
      rst    = do_rst;

      g = -1;
      if (lock_own >= 0) begin
        g = lock_own;
      end else begin
        for (int k = 0; k < BN && g < 0; k++) begin
          if (act[(ptr_m + k) % BN]) g = (ptr_m + k) % BN;
        end
      end
      e_mvld = (g >= 0) && act[g];
      xf     = e_mvld && m_rdy;
      e_rdy  = '0;
      if (xf) e_rdy[g] = 1'b1;

      #1;
      chk($sformatf("rnd%0d_mvld", c), m_vld, e_mvld);
      chk($sformatf("rnd%0d_srdy", c), s_rdy, e_rdy);
      for (int i = 0; i < BN; i++) begin
        chk($sformatf("rnd%0d_rdt%0d", c, i), s_rdt[i*DW +: DW], (resp_own == i) ? m_rdt : 32'h0);
      end
      if (e_mvld) begin
        chk($sformatf("rnd%0d_madr", c), m_adr, r_adr[g]);
        chk($sformatf("rnd%0d_mfld", c), {m_wen, m_ben, m_wdt}, {r_wen[g], r_ben[g], r_wdt[g]});
      end

      if (xf) act[g] = 1'b0;
      if (do_rst) begin
        lock_own = -1; ptr_m = 0; resp_own = -1;
      end else begin
        resp_own = xf ? g : -1;
        if (xf) begin
          lock_own = -1;
`ifdef TCB_ARB_ROUND_ROBIN_EN
          ptr_m = (g + 1) % BN;
`endif
        end else if (e_mvld) begin
          lock_own = g;
        end
      end
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
